// File: rtl/i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_init_sequencer
//
// Walks a fixed seven-entry register table and pushes each entry to a
// peripheral as a two-byte I2C write through a downstream byte-level I2C
// controller. Each transaction is: raise enable, wait for the controller to
// leave idle, present byte0 until the first write_in_progress rise, present
// byte1 until the second rise, then drop enable so the controller issues STOP
// after exactly two bytes. A fixed idle gap separates transactions. A per-state
// watchdog aborts to S_ERROR if the controller stops responding.
//
// Parameters
//   PERIPH_ADDR     7-bit target address driven on periph_addr
//   GAP_CYCLES      idle clk cycles between transactions (>= 1)
//   TIMEOUT_CYCLES  per-state watchdog limit in clk cycles (>= 1)
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   run the table; honoured only in S_IDLE/S_DONE/S_ERROR
//   ctrl_ready   in   controller idle flag
//   ctrl_wip     in   controller write_in_progress
//   enable       out  controller enable
//   mode         out  transfer direction, constant 1 (write)
//   periph_addr  out  constant PERIPH_ADDR
//   input_byte   out  byte offered to the controller
//   busy         out  table run in progress (S_START..S_GAP)
//   done         out  table completed
//   error        out  watchdog expired
//   entry_index  out  current (or last / failing) table entry
// ---------------------------------------------------------------------------
module i2c_init_sequencer #(
    parameter logic [6:0] PERIPH_ADDR    = 7'h1A,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ctrl_ready,
    input  logic       ctrl_wip,
    output logic       enable,
    output logic       mode,
    output logic [6:0] periph_addr,
    output logic [7:0] input_byte,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] entry_index
);

    // One counter serves both the watchdog and the inter-transaction gap, so
    // it is sized for whichever limit is larger.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       LAST_ENTRY   = 3'd6;

    // Four bits leave spare encodings so a corrupted state register has a
    // defined recovery path back to S_IDLE.
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_BYTE0 = 4'd2,
        S_BYTE1 = 4'd3,
        S_STOP  = 4'd4,
        S_GAP   = 4'd5,
        S_DONE  = 4'd6,
        S_ERROR = 4'd7
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       entry_q;
    logic [2:0]       entry_d;
    logic             wip_q;

    logic             wip_rise;
    logic             timed_out;
    logic             gap_over;
    logic             in_run;
    logic [15:0]      cur_entry;

    // NOTE: the init table is a constant ROM decoded from entry_index; it has
    // no storage of its own, so there is nothing to reset.
    function automatic logic [15:0] table_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    table_entry = 16'h1E00;
            3'd1:    table_entry = 16'h0C10;
            3'd2:    table_entry = 16'h0E02;
            3'd3:    table_entry = 16'h1000;
            3'd4:    table_entry = 16'h0812;
            3'd5:    table_entry = 16'h0A00;
            3'd6:    table_entry = 16'h1201;
            default: table_entry = 16'h0000;
        endcase
    endfunction

    assign cur_entry = table_entry(entry_q);
    assign wip_rise  = ctrl_wip & ~wip_q;
    assign timed_out = (cnt_q == TIMEOUT_LAST);
    assign gap_over  = (cnt_q == GAP_LAST);
    assign in_run    = (state_q == S_START) || (state_q == S_BYTE0) ||
                       (state_q == S_BYTE1) || (state_q == S_STOP)  ||
                       (state_q == S_GAP);

    // -----------------------------------------------------------------------
    // State, counter, entry and edge-detect registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            entry_q <= 3'd0;
            wip_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            entry_q <= entry_d;
            wip_q   <= ctrl_wip;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_START;
                    entry_d = 3'd0;
                end
            end
            // Progress takes priority over the watchdog when both fire on the
            // same cycle.
            S_START: begin
                if (!ctrl_ready)    state_d = S_BYTE0;
                else if (timed_out) state_d = S_ERROR;
            end
            S_BYTE0: begin
                if (wip_rise)       state_d = S_BYTE1;
                else if (timed_out) state_d = S_ERROR;
            end
            S_BYTE1: begin
                if (wip_rise)       state_d = S_STOP;
                else if (timed_out) state_d = S_ERROR;
            end
            S_STOP: begin
                if (ctrl_ready)     state_d = S_GAP;
                else if (timed_out) state_d = S_ERROR;
            end
            S_GAP: begin
                if (gap_over) begin
                    if (entry_q == LAST_ENTRY) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_START;
                        entry_d = entry_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The counter measures time spent in the current state: it restarts on
    // every transition and only runs where a limit applies.
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && in_run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (decoded from the registered state only)
    // -----------------------------------------------------------------------
    always_comb begin
        enable     = 1'b0;
        input_byte = 8'h00;
        case (state_q)
            S_START, S_BYTE0: begin
                enable     = 1'b1;
                input_byte = cur_entry[15:8];
            end
            S_BYTE1: begin
                enable     = 1'b1;
                input_byte = cur_entry[7:0];
            end
            default: begin
                enable     = 1'b0;
                input_byte = 8'h00;
            end
        endcase
    end

    assign busy        = in_run;
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERROR);
    assign entry_index = entry_q;
    assign mode        = 1'b1;
    assign periph_addr = PERIPH_ADDR;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_init_sequencer
//
// Directed bench for i2c_init_sequencer. A task-driven controller model
// answers each transaction (ready drop, two write_in_progress rises, ready
// return) and compares the offered bytes against the hand-written table.
// Scenarios: reset values, full run with a stray start mid-run, replay from
// S_DONE, reset during S_BYTE1 of entry 3, watchdog timeout, recovery.
// ---------------------------------------------------------------------------
module tb_i2c_init_sequencer;

    localparam int         GAP  = 6;
    localparam int         TMO  = 200;
    localparam logic [6:0] ADDR = 7'h1A;

    logic       clk;
    logic       reset;
    logic       start;
    logic       ctrl_ready;
    logic       ctrl_wip;
    logic       enable;
    logic       mode;
    logic [6:0] periph_addr;
    logic [7:0] input_byte;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] entry_index;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_ready_cyc;

    logic [7:0] exp_bytes [14] = '{8'h1E, 8'h00, 8'h0C, 8'h10, 8'h0E, 8'h02, 8'h10,
                                   8'h00, 8'h08, 8'h12, 8'h0A, 8'h00, 8'h12, 8'h01};

    i2c_init_sequencer #(
        .PERIPH_ADDR   (ADDR),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ctrl_ready (ctrl_ready),
        .ctrl_wip   (ctrl_wip),
        .enable     (enable),
        .mode       (mode),
        .periph_addr(periph_addr),
        .input_byte (input_byte),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .entry_index(entry_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One two-byte write as seen by the controller model.
    // mode_sel: 0 normal, 1 stray start during S_BYTE0, 2 reset during S_BYTE1.
    task automatic run_txn(input int idx, input int mode_sel, output bit aborted);
        int n;
        aborted = 1'b0;
        n = 0;
        while (enable !== 1'b1 && n < GAP + 20) begin
            tick();
            n++;
        end
        check("enable_wait", 32'(enable), 32'd1);
        if (last_ready_cyc >= 0) check("gap_cycles", 32'(cyc - last_ready_cyc), 32'(GAP + 1));
        check("entry_index", 32'(entry_index), 32'(idx));

        tick();
        tick();
        ctrl_ready = 1'b0;
        if (mode_sel == 1) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            tick();
        end else begin
            repeat (3) tick();
        end

        ctrl_wip = 1'b1;
        check("en_rise1", 32'(enable), 32'd1);
        check("byte0", 32'(input_byte), 32'(exp_bytes[2*idx]));
        repeat (4) tick();
        ctrl_wip = 1'b0;

        if (mode_sel == 2) begin
            reset = 1'b1;
            tick();
            reset      = 1'b0;
            ctrl_ready = 1'b1;
            check("rst_enable", 32'(enable), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_entry", 32'(entry_index), 32'd0);
            aborted        = 1'b1;
            last_ready_cyc = -1;
            return;
        end

        repeat (2) tick();
        ctrl_wip = 1'b1;
        check("en_rise2", 32'(enable), 32'd1);
        check("byte1", 32'(input_byte), 32'(exp_bytes[2*idx+1]));
        tick();
        check("stop_after_2", 32'(enable), 32'd0);
        check("busy_in_stop", 32'(busy), 32'd1);
        repeat (2) tick();
        ctrl_wip = 1'b0;
        repeat (2) tick();
        ctrl_ready     = 1'b1;
        last_ready_cyc = cyc;
    endtask

    // Whole table run; expects the sequencer to be in S_START already.
    task automatic run_seq(input int abort_idx, input int start_idx);
        bit ab;
        int n;
        last_ready_cyc = -1;
        for (int i = 0; i < 7; i++) begin
            run_txn(i, (i == start_idx) ? 1 : ((i == abort_idx) ? 2 : 0), ab);
            if (ab) return;
        end
        n = 0;
        while (done !== 1'b1 && n < GAP + 20) begin
            tick();
            n++;
        end
        check("done", 32'(done), 32'd1);
        check("done_entry", 32'(entry_index), 32'd6);
        check("done_busy", 32'(busy), 32'd0);
        check("done_error", 32'(error), 32'd0);
        check("done_byte", 32'(input_byte), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        ctrl_ready     = 1'b1;
        ctrl_wip       = 1'b0;
        last_ready_cyc = -1;

        // Reset values, sampled while reset is still asserted.
        repeat (3) tick();
        check("rst_mode", 32'(mode), 32'd1);
        check("rst_addr", 32'(periph_addr), 32'(ADDR));
        check("rst_en", 32'(enable), 32'd0);
        check("rst_byte", 32'(input_byte), 32'd0);
        check("rst_busy0", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_index", 32'(entry_index), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_en", 32'(enable), 32'd0);

        // Full run with a stray start while entry 2 is in flight.
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        run_seq(-1, 2);

        // Start from S_DONE replays and clears done; abort with reset in entry 3.
        pulse_start();
        check("replay_done_clr", 32'(done), 32'd0);
        check("replay_entry", 32'(entry_index), 32'd0);
        run_seq(3, -1);

        // After the mid-run reset a new start replays from entry 0.
        pulse_start();
        run_seq(-1, -1);

        // Controller never leaves idle: watchdog expires in S_START.
        ctrl_ready = 1'b1;
        pulse_start();
        repeat (TMO - 1) tick();
        check("pre_timeout_err", 32'(error), 32'd0);
        check("pre_timeout_en", 32'(enable), 32'd1);
        tick();
        check("timeout_err", 32'(error), 32'd1);
        check("timeout_en", 32'(enable), 32'd0);
        check("timeout_entry", 32'(entry_index), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_mode", 32'(mode), 32'd1);

        // Recovery from S_ERROR.
        pulse_start();
        check("recover_err_clr", 32'(error), 32'd0);
        run_seq(-1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
